instr_fetch_unit: RTL

- Fetch stage feeding the instruction decoder/control path of the RISC-V core.
- Holds the architectural PC and issues in-order word fetches to instruction memory over a valid/ready request and valid-only response interface.
- Buffers returned words in a small FIFO and presents {instrCode, instr_pc} to the decode stage with a valid/ready handshake.
- Handles branch/jal/jalr redirects by flushing buffered and in-flight fetches.

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decode-side handshake.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instrCode;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instrCode, instr_pc,
        input  instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instrCode, instr_pc,
        output instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// In-order fetch stage: PC, outstanding/drop tracking, tag queue and instruction FIFO.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {RUN, FLUSH} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW-1:0] trd_q, trd_d, twr_q, twr_d;
    logic [31:0]   code_q [FIFO_DEPTH];
    logic [31:0]   code_d [FIFO_DEPTH];
    logic [31:0]   pc_q   [FIFO_DEPTH];
    logic [31:0]   pc_d   [FIFO_DEPTH];
    logic [31:0]   tag_q  [FIFO_DEPTH];
    logic [31:0]   tag_d  [FIFO_DEPTH];

    logic          fifo_valid, pop, push, byp;
    logic          req_fire, rsp_ok, drop;
    logic [CW:0]   load;

    // A same-cycle pop frees a slot, which keeps a 1-cycle memory at full rate.
    always_comb begin
        fifo_valid = cnt_q != '0;
        pop        = fifo_valid && bus.instr_ready && !bus.redirect;
        load       = {1'b0, out_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
        req_fire   = bus.imem_req_valid && bus.imem_req_ready;
        rsp_ok     = bus.imem_rsp_valid && (out_q != '0);
        drop       = (state_q == FLUSH) || bus.redirect;
`ifdef FETCH_BYPASS_EN
        byp        = !reset && rsp_ok && !drop && !fifo_valid;
`else
        byp        = 1'b0;
`endif
        push       = rsp_ok && !drop && !(byp && bus.instr_ready);
    end

    assign bus.imem_req_valid = !reset && !bus.redirect && (load < DEPTH_L);
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = fifo_valid || byp;
    assign bus.instrCode      = byp ? bus.imem_rsp_data : code_q[rd_q];
    assign bus.instr_pc       = byp ? tag_q[trd_q] : pc_q[rd_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q + CW'(req_fire) - CW'(rsp_ok);
        drop_d     = drop_q;
        twr_d      = twr_q + AW'(req_fire);
        trd_d      = trd_q + AW'(rsp_ok);
        rd_d       = rd_q + AW'(pop);
        wr_d       = wr_q + AW'(push);
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        code_d     = code_q;
        pc_d       = pc_q;
        tag_d      = tag_q;
        if (req_fire) begin
            fetch_pc_d   = fetch_pc_q + 32'd4;
            tag_d[twr_q] = fetch_pc_q;
        end
        if (push) begin
            code_d[wr_q] = bus.imem_rsp_data;
            pc_d[wr_q]   = tag_q[trd_q];
        end
        // Every fetch still in flight at a redirect belongs to the old path.
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc & ~32'h3;
            drop_d     = out_q - CW'(rsp_ok);
            rd_d       = wr_q;
            cnt_d      = '0;
        end else if (rsp_ok && state_q == FLUSH) begin
            drop_d = drop_q - 1'b1;
        end
        state_d = (drop_d != '0) ? FLUSH : RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            trd_q      <= '0;
            twr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                code_q[i] <= '0;
                pc_q[i]   <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            trd_q      <= trd_d;
            twr_q      <= twr_d;
            code_q     <= code_d;
            pc_q       <= pc_d;
            tag_q      <= tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(bus.imem_rsp_valid && out_q == '0));
        end
    end
endmodule
